// File: rtl/pe_pkg.sv
// Shared definitions for the MAC processing element family: default widths,
// the saturation constant and the stage-1 control record.
package pe_pkg;

    localparam int WORD_SIZE_DEF  = 8;
    localparam int ACC_WIDTH_DEF  = 20;
    localparam int TRUNC_BITS_DEF = 2;

    function automatic longint unsigned ACC_MAX(input int acc_width);
        return (64'd1 << acc_width) - 64'd1;
    endfunction

    // Product width depends on the instance parameters, so the full record
    // (product plus these flags) is assembled inside each PE.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } s1_ctrl_t;

endpackage

// File: rtl/approx_mult.sv
// Unsigned multiplier whose operand LSBs can be zeroed per beat to model
// a cheaper approximate datapath.
module approx_mult
    import pe_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int TRUNC_BITS = TRUNC_BITS_DEF
) (
    input  logic [WORD_SIZE-1:0]   a,
    input  logic [WORD_SIZE-1:0]   w,
    input  logic                   approx_en,
    output logic [2*WORD_SIZE-1:0] p
);

    localparam logic [WORD_SIZE-1:0] TRUNC_MASK = ~WORD_SIZE'((1 << TRUNC_BITS) - 1);

    logic [WORD_SIZE-1:0] mask;
    logic [WORD_SIZE-1:0] am;
    logic [WORD_SIZE-1:0] wm;

    always_comb begin
        mask = approx_en ? TRUNC_MASK : '1;
        am   = a & mask;
        wm   = w & mask;
        p    = (2*WORD_SIZE)'(am) * (2*WORD_SIZE)'(wm);
    end

endmodule

// File: rtl/mac_pe.sv
// Systolic MAC processing element: forwards operands east/south and
// accumulates framed dot products into a saturating, handshaked result buffer.
module mac_pe
    import pe_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int TRUNC_BITS = TRUNC_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic                 approx_en,
    input  logic [WORD_SIZE-1:0] ain,
    input  logic [WORD_SIZE-1:0] win,
    output logic [WORD_SIZE-1:0] aout,
    output logic [WORD_SIZE-1:0] wout,
    output logic                 vout,
    output logic [ACC_WIDTH-1:0] res,
    output logic                 res_sat,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_ovf
);

    localparam logic [ACC_WIDTH-1:0] SAT_VAL = ACC_WIDTH'(ACC_MAX(ACC_WIDTH));

    typedef struct packed {
        logic [ACC_WIDTH-1:0] p;
        s1_ctrl_t             ctrl;
    } s1_rec_t;

    logic [2*WORD_SIZE-1:0] prod;
    s1_rec_t                s1;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   sat;
    logic [ACC_WIDTH-1:0]   base;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   clamped;
    logic                   sat_next;

    approx_mult #(
        .WORD_SIZE (WORD_SIZE),
        .TRUNC_BITS(TRUNC_BITS)
    ) u_mult (
        .a        (ain),
        .w        (win),
        .approx_en(approx_en),
        .p        (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            aout <= '0;
            wout <= '0;
            vout <= 1'b0;
        end else begin
            aout <= ain;
            wout <= win;
            vout <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
        end else begin
            s1.p          <= ACC_WIDTH'(prod);
            s1.ctrl.valid <= in_valid;
            s1.ctrl.first <= in_first;
            s1.ctrl.last  <= in_last;
        end
    end

    // The extra sum bit is the overflow indicator; a first beat restarts both
    // the partial sum and the saturation history.
    always_comb begin
        base     = s1.ctrl.first ? '0 : acc;
        sum      = {1'b0, base} + {1'b0, s1.p};
        clamped  = sum[ACC_WIDTH] ? SAT_VAL : sum[ACC_WIDTH-1:0];
        sat_next = (s1.ctrl.first ? 1'b0 : sat) | sum[ACC_WIDTH];
    end

    // A completing frame has priority over the consumer's handshake, so the
    // later assignment to res_valid deliberately overrides the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            sat       <= 1'b0;
            res       <= '0;
            res_sat   <= 1'b0;
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (s1.ctrl.valid) begin
                if (s1.ctrl.last) begin
                    res       <= clamped;
                    res_sat   <= sat_next;
                    res_valid <= 1'b1;
                    acc       <= '0;
                    sat       <= 1'b0;
                    if (res_valid && !res_ready) begin
                        res_ovf <= 1'b1;
                    end
                end else begin
                    acc <= clamped;
                    sat <= sat_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pe.sv
// Directed bench for mac_pe: a transaction-level model tracks the expected
// outputs every cycle, and literal expectations pin both DUT and model.
module tb_mac_pe;
   import pe_pkg::*;

   localparam int W = 8;
   localparam int A = 20;
   localparam int T = 2;
   localparam int MAXV = (1 << A) - 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_first;
   logic          in_last;
   logic          approx_en;
   logic [W-1:0]  ain;
   logic [W-1:0]  win;
   logic [W-1:0]  aout;
   logic [W-1:0]  wout;
   logic          vout;
   logic [A-1:0]  res;
   logic          res_sat;
   logic          res_valid;
   logic          res_ready;
   logic          res_ovf;

   mac_pe #(
      .WORD_SIZE (W),
      .ACC_WIDTH (A),
      .TRUNC_BITS(T)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_first (in_first),
      .in_last  (in_last),
      .approx_en(approx_en),
      .ain      (ain),
      .win      (win),
      .aout     (aout),
      .wout     (wout),
      .vout     (vout),
      .res      (res),
      .res_sat  (res_sat),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_ovf  (res_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit checkEn = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: the dot product is accumulated when the beat is seen
   // and the finished result is released to the buffer one edge later.
   int   mAcc;
   bit   mAccSat;
   bit   pendHas;
   int   pendRes;
   bit   pendSat;
   int   mRes;
   bit   mResSat;
   bit   mValid;
   bit   mOvf;
   int   mAout;
   int   mWout;
   bit   mVout;
   bit   oldValid;
   int   pa;
   int   pw;

   always @(posedge clk) begin
      if (rst) begin
         mAcc = 0; mAccSat = 0; pendHas = 0; pendRes = 0; pendSat = 0;
         mRes = 0; mResSat = 0; mValid = 0; mOvf = 0;
         mAout = 0; mWout = 0; mVout = 0;
      end else begin
         oldValid = mValid;
         if (mValid && res_ready) mValid = 0;
         if (pendHas) begin
            if (oldValid && !res_ready) mOvf = 1;
            mRes    = pendRes;
            mResSat = pendSat;
            mValid  = 1;
            pendHas = 0;
         end
         if (in_valid) begin
            pa = approx_en ? (int'(ain) / (1 << T)) * (1 << T) : int'(ain);
            pw = approx_en ? (int'(win) / (1 << T)) * (1 << T) : int'(win);
            if (in_first) begin
               mAcc    = 0;
               mAccSat = 0;
            end
            mAcc = mAcc + pa * pw;
            if (mAcc > MAXV) begin
               mAcc    = MAXV;
               mAccSat = 1;
            end
            if (in_last) begin
               pendHas = 1;
               pendRes = mAcc;
               pendSat = mAccSat;
               mAcc    = 0;
               mAccSat = 0;
            end
         end
         mAout = int'(ain);
         mWout = int'(win);
         mVout = in_valid;
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("cyc_aout", 32'(aout), mAout);
         checkOutput("cyc_wout", 32'(wout), mWout);
         checkOutput("cyc_vout", 32'(vout), 32'(mVout));
         checkOutput("cyc_res_valid", 32'(res_valid), 32'(mValid));
         checkOutput("cyc_res", 32'(res), mRes);
         checkOutput("cyc_res_sat", 32'(res_sat), 32'(mResSat));
         checkOutput("cyc_res_ovf", 32'(res_ovf), 32'(mOvf));
      end
   end

   task automatic applyStimulus(input logic v, input logic f, input logic l,
                                input logic ap, input logic [W-1:0] a, input logic [W-1:0] w);
      in_valid  = v;
      in_first  = f;
      in_last   = l;
      approx_en = ap;
      ain       = a;
      win       = w;
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic waitResult(input string name, input int expRes, input logic expSat);
      int n = 0;
      while (res_valid !== 1'b1 && n < 20) begin
         idle();
         n++;
      end
      if (res_valid !== 1'b1) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_timeout: got res_valid=%b expected 1 within 20 cycles", name, res_valid);
      end else begin
         checkOutput({name, "_res"}, 32'(res), expRes);
         checkOutput({name, "_sat"}, 32'(res_sat), 32'(expSat));
         checkOutput({name, "_model"}, mRes, expRes);
      end
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_aout"}, 32'(aout), 0);
      checkOutput({name, "_wout"}, 32'(wout), 0);
      checkOutput({name, "_vout"}, 32'(vout), 0);
      checkOutput({name, "_res"}, 32'(res), 0);
      checkOutput({name, "_res_sat"}, 32'(res_sat), 0);
      checkOutput({name, "_res_valid"}, 32'(res_valid), 0);
      checkOutput({name, "_res_ovf"}, 32'(res_ovf), 0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 0; in_first = 0; in_last = 0; approx_en = 0;
      ain = '0; win = '0; res_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      checkEn = 1'b1;

      // exact frame, latency and pulse width
      applyStimulus(1, 1, 0, 0, 3, 5);
      checkOutput("t1_aout_lag", 32'(aout), 3);
      checkOutput("t1_wout_lag", 32'(wout), 5);
      applyStimulus(1, 0, 0, 0, 3, 5);
      applyStimulus(1, 0, 0, 0, 3, 5);
      applyStimulus(1, 0, 1, 0, 3, 5);
      checkOutput("t1_valid_e0", 32'(res_valid), 0);
      idle();
      checkOutput("t1_valid_e1", 32'(res_valid), 1);
      checkOutput("t1_res", 32'(res), 60);
      checkOutput("t1_sat", 32'(res_sat), 0);
      idle();
      checkOutput("t1_pulse_end", 32'(res_valid), 0);

      // approximate versus exact multiply
      applyStimulus(1, 1, 1, 1, 7, 7);
      waitResult("t2_approx", 16, 1'b0);
      applyStimulus(1, 1, 1, 0, 7, 7);
      waitResult("t2_exact", 49, 1'b0);

      // saturation, then a clean frame
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, i == 0, i == 19, 0, 255, 255);
      end
      waitResult("t3_sat", MAXV, 1'b1);
      applyStimulus(1, 1, 1, 0, 2, 2);
      waitResult("t3_after", 4, 1'b0);
      idle();

      // backpressure and overwrite
      res_ready = 1'b0;
      applyStimulus(1, 1, 1, 0, 2, 3);
      applyStimulus(1, 1, 1, 0, 2, 5);
      idle();
      idle();
      checkOutput("t4_res", 32'(res), 10);
      checkOutput("t4_valid", 32'(res_valid), 1);
      checkOutput("t4_ovf", 32'(res_ovf), 1);
      res_ready = 1'b1;
      idle();
      checkOutput("t4_drain", 32'(res_valid), 0);
      checkOutput("t4_ovf_sticky", 32'(res_ovf), 1);

      // restart discards the partial sum
      applyStimulus(1, 1, 0, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 2, 2);
      applyStimulus(1, 1, 1, 0, 3, 3);
      waitResult("t5_restart", 9, 1'b0);
      idle();

      // reset in the middle of a frame, with a live beat presented during rst
      applyStimulus(1, 1, 0, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 2, 2);
      rst = 1'b1;
      applyStimulus(1, 0, 1, 0, 9, 9);
      checkAllZero("t6_rst");
      rst = 1'b0;
      applyStimulus(1, 1, 1, 0, 2, 3);
      checkOutput("t6_aout", 32'(aout), 2);
      checkOutput("t6_inflight", 32'(res_valid), 0);
      waitResult("t6_after_rst", 6, 1'b0);
      checkOutput("t6_ovf_cleared", 32'(res_ovf), 0);
      idle();
      idle();

      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
